// File: rtl/subtractor_seq.sv
// Two-cycle 64-bit subtractor: one HALF_W-bit subtract stage is reused for the low
// half and then the high half, with the borrow chained between them.
module subtractor_seq #(
  parameter int HALF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [HALF_W-1:0] operand1_H,
  input  logic [HALF_W-1:0] operand1_L,
  input  logic [HALF_W-1:0] operand2_H,
  input  logic [HALF_W-1:0] operand2_L,
  input  logic              bin,
  output logic              busy,
  output logic              done,
  output logic [HALF_W-1:0] result_H,
  output logic [HALF_W-1:0] result_L,
  output logic              bout,
  output logic              overflow,
  output logic              zero
);

  // Handshake: start is accepted on a rising edge only when busy==0 (IDLE or DONE);
  // done is high for exactly one cycle and results then hold until the next done.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [HALF_W-1:0] r_a_h, r_a_l, r_b_h, r_b_l;
  logic              r_bin;
  logic [HALF_W-1:0] r_diff_l;
  logic              r_brw_l;
  logic [HALF_W-1:0] r_result_h, r_result_l;
  logic              r_bout, r_ovf, r_zero;

  logic              w_accept;
  logic [HALF_W-1:0] w_op_a, w_op_b;
  logic              w_op_c;
  logic [HALF_W:0]   w_sub;

  assign w_accept = (r_state == ST_IDLE || r_state == ST_DONE) && start;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOW;
      ST_LOW:  w_next = ST_HIGH;
      ST_HIGH: w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_LOW : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Shared subtract stage: low half with bin, then high half with the low borrow.
  always_comb begin
    w_op_a = r_a_l;
    w_op_b = r_b_l;
    w_op_c = r_bin;
    if (r_state == ST_HIGH) begin
      w_op_a = r_a_h;
      w_op_b = r_b_h;
      w_op_c = r_brw_l;
    end
  end

  assign w_sub = {1'b0, w_op_a} - {1'b0, w_op_b} - {{HALF_W{1'b0}}, w_op_c};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a_h      <= '0;
      r_a_l      <= '0;
      r_b_h      <= '0;
      r_b_l      <= '0;
      r_bin      <= 1'b0;
      r_diff_l   <= '0;
      r_brw_l    <= 1'b0;
      r_result_h <= '0;
      r_result_l <= '0;
      r_bout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_zero     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a_h <= operand1_H;
        r_a_l <= operand1_L;
        r_b_h <= operand2_H;
        r_b_l <= operand2_L;
        r_bin <= bin;
      end
      if (r_state == ST_LOW) begin
        r_diff_l <= w_sub[HALF_W-1:0];
        r_brw_l  <= w_sub[HALF_W];
      end
      // All visible results change together so no half-updated value is ever seen.
      if (r_state == ST_HIGH) begin
        r_result_h <= w_sub[HALF_W-1:0];
        r_result_l <= r_diff_l;
        r_bout     <= w_sub[HALF_W];
        r_ovf      <= (r_a_h[HALF_W-1] != r_b_h[HALF_W-1]) &&
                      (w_sub[HALF_W-1] != r_a_h[HALF_W-1]);
        r_zero     <= (w_sub[HALF_W-1:0] == '0) && (r_diff_l == '0);
      end
    end
  end

  assign busy     = (r_state == ST_LOW) || (r_state == ST_HIGH);
  assign done     = (r_state == ST_DONE);
  assign result_H = r_result_h;
  assign result_L = r_result_l;
  assign bout     = r_bout;
  assign overflow = r_ovf;
  assign zero     = r_zero;

endmodule

// File: tb/tb_subtractor_seq.sv
// Bench for subtractor_seq: directed vector table, random operations against a 64-bit
// arithmetic model, back-to-back issue with start held, and reset during HIGH.
module tb_subtractor_seq;
  localparam int HW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [HW-1:0] operand1_H, operand1_L, operand2_H, operand2_L;
  logic          bin;
  logic          busy, done, bout, overflow, zero;
  logic [HW-1:0] result_H, result_L;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        bin;
    logic [63:0] r;
    logic        bo;
    logic        ov;
    logic        z;
  } vec_t;

  vec_t        tbl[5];
  logic [63:0] exp_q[$];
  logic [2:0]  expf_q[$];

  subtractor_seq #(.HALF_W(HW)) dut (
    .clk(clk), .reset(reset), .start(start),
    .operand1_H(operand1_H), .operand1_L(operand1_L),
    .operand2_H(operand2_H), .operand2_L(operand2_L),
    .bin(bin), .busy(busy), .done(done),
    .result_H(result_H), .result_L(result_L),
    .bout(bout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on whole operands.
  function automatic void model(input logic [63:0] a, input logic [63:0] b, input logic bi,
                                output logic [63:0] r, output logic bo, output logic ov,
                                output logic z);
    logic [64:0] rhs;
    rhs = {1'b0, b} + {64'd0, bi};
    r   = a - b - {63'd0, bi};
    bo  = ({1'b0, a} < rhs);
    ov  = (a[63] != b[63]) && (r[63] != a[63]);
    z   = (r == 64'd0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [63:0] r, input logic bo,
                            input logic ov, input logic z);
    check({tag, " result"}, {result_H, result_L}, r);
    check({tag, " bout"}, {63'd0, bout}, {63'd0, bo});
    check({tag, " overflow"}, {63'd0, overflow}, {63'd0, ov});
    check({tag, " zero"}, {63'd0, zero}, {63'd0, z});
  endtask

  task automatic drive_ops(input logic [63:0] a, input logic [63:0] b, input logic bi);
    operand1_H = a[63:32];
    operand1_L = a[31:0];
    operand2_H = b[63:32];
    operand2_L = b[31:0];
    bin        = bi;
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or budget expires).
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic bi,
                        output int lat);
    start = 1'b1;
    drive_ops(a, b, bi);
    lat = 0;
    @(negedge clk);
    start = 1'b0;
    drive_ops($urandom, $urandom, 1'($urandom));
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    logic [63:0] a, b, r, prev_r;
    logic        bi, bo, ov, z, prev_bo, prev_ov, prev_z;
    int          lat;
    logic [2:0]  f;

    tbl[0] = '{64'h00000001_00000000, 64'h1, 1'b0, 64'h00000000_FFFFFFFF, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{64'h0, 64'h1, 1'b0, 64'hFFFFFFFF_FFFFFFFF, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{64'h80000000_00000000, 64'h1, 1'b0, 64'h7FFFFFFF_FFFFFFFF, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b1, 64'hFFFFFFFF_FFFFFFFF,
               1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    drive_ops(64'h0, 64'h0, 1'b0);
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check_outs("reset", 64'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].bin, lat);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'd3);
      check_outs($sformatf("vec%0d", i), tbl[i].r, tbl[i].bo, tbl[i].ov, tbl[i].z);
      @(negedge clk);
      check($sformatf("vec%0d done width", i), {63'd0, done}, 64'd0);
    end

    // Random operations, with occasional borrow-boundary operands
    for (int i = 0; i < 40; i++) begin
      a  = {$urandom, $urandom};
      b  = (i % 5 == 0) ? a : {$urandom, $urandom};
      bi = 1'($urandom_range(0, 1));
      if (i % 7 == 0) a[31:0] = 32'd0;
      model(a, b, bi, r, bo, ov, z);
      run_op(a, b, bi, lat);
      check($sformatf("rnd%0d latency", i), 64'(lat), 64'd3);
      check_outs($sformatf("rnd%0d", i), r, bo, ov, z);
      @(negedge clk);
    end

    // start held high: acceptances every 3rd edge from an idle start
    prev_r  = {result_H, result_L};
    prev_bo = bout;
    prev_ov = overflow;
    prev_z  = zero;
    start   = 1'b1;
    for (int i = 0; i < 18; i++) begin
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      bi = 1'($urandom_range(0, 1));
      drive_ops(a, b, bi);
      if (i % 3 == 0) begin
        model(a, b, bi, r, bo, ov, z);
        exp_q.push_back(r);
        expf_q.push_back({bo, ov, z});
      end
      @(negedge clk);
      check($sformatf("hold%0d done", i), {63'd0, done}, {63'd0, (i % 3 == 2)});
      if (done && exp_q.size() > 0) begin
        r = exp_q.pop_front();
        f = expf_q.pop_front();
        check_outs($sformatf("hold%0d", i), r, f[2], f[1], f[0]);
        prev_r  = r;
        prev_bo = f[2];
        prev_ov = f[1];
        prev_z  = f[0];
      end else begin
        check_outs($sformatf("hold%0d stable", i), prev_r, prev_bo, prev_ov, prev_z);
      end
    end
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset while in HIGH: outputs clear, no done follows
    start = 1'b1;
    drive_ops(64'h5, 64'h3, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre-reset busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst-high busy", {63'd0, busy}, 64'd0);
    check("rst-high done", {63'd0, done}, 64'd0);
    check_outs("rst-high", 64'd0, 1'b0, 1'b0, 1'b0);
    lat = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) lat++;
    end
    check("rst-high no done", 64'(lat), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
